// File: rtl/aq_rtu_wb_arb_pkg.sv
// Shared RTU writeback-arbiter package.
// Holds the writeback field widths, the starvation FSM encoding and a
// saturating counter helper.
package aq_rtu_wb_arb_pkg;

  localparam int PREG_W = 6;
  localparam int DATA_W = 64;

  // Slot indices. Index 0 is the VPU, index 1 is the divider.
  localparam int SLOT_NUM = 2;
  localparam int SLOT_VPU = 0;
  localparam int SLOT_DIV = 1;

  // Encoding of the starvation FSM.
  typedef enum logic [1:0] {
    ARB_NORMAL = 2'b00,
    ARB_STALL  = 2'b01,
    ARB_DRAIN  = 2'b10
  } arb_state_e;

  // Increment that stops at limit. Used by the starvation counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] limit);
    return (cnt >= limit) ? limit : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/aq_rtu_wb_slot.sv
// Single-entry writeback holding register.
// The valid bit is set on capture and cleared on drain. If capture and drain
// happen in the same cycle, capture wins, so a slot can be drained and
// refilled in one cycle. The preg/data registers load only on capture and
// are not reset.
module aq_rtu_wb_slot
  import aq_rtu_wb_arb_pkg::*;
(
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              capture,
  input  logic              drain,
  input  logic [PREG_W-1:0] cap_preg,
  input  logic [DATA_W-1:0] cap_data,
  output logic              vld,
  output logic [PREG_W-1:0] preg,
  output logic [DATA_W-1:0] data
);

  logic              vld_reg;
  logic [PREG_W-1:0] preg_reg;
  logic [DATA_W-1:0] data_reg;

  // Track occupancy. Reset discards any held entry.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      vld_reg <= 1'b0;
    end else if (capture) begin
      vld_reg <= 1'b1;
    end else if (drain) begin
      vld_reg <= 1'b0;
    end
  end

  // Payload registers. These carry no reset and load only on capture.
  always_ff @(posedge forever_cpuclk) begin
    if (capture) begin
      preg_reg <= cap_preg;
      data_reg <= cap_data;
    end
  end

  assign vld  = vld_reg;
  assign preg = preg_reg;
  assign data = data_reg;

endmodule

// File: rtl/aq_rtu_wb_arb.sv
// RTU writeback port-0 arbiter.
// The rbus writeback always owns wb0. VPU and divider results wait in
// one-entry slots and are drained when rbus is idle. A 1-bit round-robin
// pointer decides between them when both are pending.
// Optional feature: define AQ_RTU_WB_ARB_STARVE_EN to build the starvation
// counter and FSM. The FSM asks the IDU to stop issuing rbus producers when
// slots wait too long. Without the macro, rtu_idu_issue_stall is tied low.
module aq_rtu_wb_arb
  import aq_rtu_wb_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
)
(
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              rbus_wb_vld,
  input  logic [PREG_W-1:0] rbus_wb_preg,
  input  logic [DATA_W-1:0] rbus_wb_data,
  input  logic              vpu_wb_req,
  input  logic [PREG_W-1:0] vpu_wb_preg,
  input  logic [DATA_W-1:0] vpu_wb_data,
  output logic              vpu_wb_grnt,
  input  logic              div_wb_req,
  input  logic [PREG_W-1:0] div_wb_preg,
  input  logic [DATA_W-1:0] div_wb_data,
  output logic              div_wb_grnt,
  output logic              wb0_vld,
  output logic [PREG_W-1:0] wb0_preg,
  output logic [DATA_W-1:0] wb0_data,
  output logic              rtu_idu_issue_stall,
  output logic              wb_arb_idle
);

  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  logic [SLOT_NUM-1:0] slot_req;
  logic [PREG_W-1:0]   slot_req_preg [SLOT_NUM];
  logic [DATA_W-1:0]   slot_req_data [SLOT_NUM];
  logic [SLOT_NUM-1:0] slot_vld;
  logic [PREG_W-1:0]   slot_preg [SLOT_NUM];
  logic [DATA_W-1:0]   slot_data [SLOT_NUM];
  logic [SLOT_NUM-1:0] slot_drain;
  logic [SLOT_NUM-1:0] slot_block;
  logic [SLOT_NUM-1:0] slot_grnt;
  logic [SLOT_NUM-1:0] slot_capture;

  logic rr_ptr_reg;
  logic rr_ptr_next;
  logic contested;

  assign slot_req[SLOT_VPU]      = vpu_wb_req;
  assign slot_req_preg[SLOT_VPU] = vpu_wb_preg;
  assign slot_req_data[SLOT_VPU] = vpu_wb_data;
  assign slot_req[SLOT_DIV]      = div_wb_req;
  assign slot_req_preg[SLOT_DIV] = div_wb_preg;
  assign slot_req_data[SLOT_DIV] = div_wb_data;

  // Instantiate one holding slot per requester.
  // A requester gets a grant when its slot is free, or when the slot is
  // draining this cycle, unless the drain phase is blocking it.
  genvar gi;
  generate
    for (gi = 0; gi < SLOT_NUM; gi++) begin : g_slot
      assign slot_grnt[gi]    = (!slot_vld[gi] || slot_drain[gi]) && !slot_block[gi];
      assign slot_capture[gi] = slot_req[gi] && slot_grnt[gi];

      aq_rtu_wb_slot u_slot (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .capture        (slot_capture[gi]),
        .drain          (slot_drain[gi]),
        .cap_preg       (slot_req_preg[gi]),
        .cap_data       (slot_req_data[gi]),
        .vld            (slot_vld[gi]),
        .preg           (slot_preg[gi]),
        .data           (slot_data[gi])
      );
    end
  endgenerate

  assign vpu_wb_grnt = slot_grnt[SLOT_VPU];
  assign div_wb_grnt = slot_grnt[SLOT_DIV];

  // Choose which pending slot drains to wb0 this cycle. Nothing drains while
  // rbus owns the port. When both slots are pending, the pointer chooses.
  always_comb begin
    slot_drain = '0;
    contested  = !rbus_wb_vld && slot_vld[SLOT_VPU] && slot_vld[SLOT_DIV];
    if (!rbus_wb_vld) begin
      if (contested) begin
        slot_drain[rr_ptr_reg] = 1'b1;
      end else begin
        slot_drain = slot_vld;
      end
    end
  end

  // Drive wb0 with rbus priority, then the draining slot. Otherwise wb0 is idle.
  always_comb begin
    wb0_vld  = 1'b0;
    wb0_preg = '0;
    wb0_data = '0;
    if (rbus_wb_vld) begin
      wb0_vld  = 1'b1;
      wb0_preg = rbus_wb_preg;
      wb0_data = rbus_wb_data;
    end else if (slot_drain[SLOT_VPU]) begin
      wb0_vld  = 1'b1;
      wb0_preg = slot_preg[SLOT_VPU];
      wb0_data = slot_data[SLOT_VPU];
    end else if (slot_drain[SLOT_DIV]) begin
      wb0_vld  = 1'b1;
      wb0_preg = slot_preg[SLOT_DIV];
      wb0_data = slot_data[SLOT_DIV];
    end
  end

  // Move the round-robin pointer to the other requester only after a contested pick.
  always_comb begin
    rr_ptr_next = contested ? !rr_ptr_reg : rr_ptr_reg;
  end

  // Round-robin pointer register.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      rr_ptr_reg <= 1'b0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  assign wb_arb_idle = !slot_vld[SLOT_VPU] && !slot_vld[SLOT_DIV] && !wb0_vld;

`ifdef AQ_RTU_WB_ARB_STARVE_EN
  arb_state_e          state_reg;
  arb_state_e          state_next;
  logic [3:0]          starve_cnt_reg;
  logic [3:0]          starve_cnt_next;
  logic [SLOT_NUM-1:0] drained_reg;
  logic [SLOT_NUM-1:0] drained_next;
  logic                any_pend;

  assign any_pend = |slot_vld;

  // Count the cycles in which pending work is held off by rbus.
  // Any drain is forward progress, so it restarts the count.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (|slot_drain) begin
      starve_cnt_next = 4'd0;
    end else if (any_pend && rbus_wb_vld) begin
      starve_cnt_next = sat_inc(starve_cnt_reg, LIMIT_C);
    end
  end

  // Advance the starvation FSM and record which slots drained while stalled.
  // A slot that has drained during STALL or DRAIN must not refill in DRAIN.
  // This includes its drain cycle. Blocking these slots stops DRAIN from
  // being extended forever by requesters that keep coming back.
  always_comb begin
    state_next   = state_reg;
    drained_next = '0;
    slot_block   = '0;
    case (state_reg)
      ARB_NORMAL: begin
        if (starve_cnt_reg == LIMIT_C) begin
          state_next = ARB_STALL;
        end
      end
      ARB_STALL: begin
        drained_next = drained_reg | slot_drain;
        if (!rbus_wb_vld) begin
          state_next = ARB_DRAIN;
        end
      end
      ARB_DRAIN: begin
        drained_next = drained_reg | slot_drain;
        slot_block   = drained_reg | slot_drain;
        if (!any_pend) begin
          state_next   = ARB_NORMAL;
          drained_next = '0;
        end
      end
      default: begin
        state_next = ARB_NORMAL;
      end
    endcase
  end

  // Starvation counter, FSM state and drained-slot flags.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state_reg      <= ARB_NORMAL;
      starve_cnt_reg <= 4'd0;
      drained_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      drained_reg    <= drained_next;
    end
  end

  assign rtu_idu_issue_stall = (state_reg != ARB_NORMAL);
`else
  // Without starvation control the limit has no effect.
  logic unused_starve_limit;
  assign unused_starve_limit = ^LIMIT_C;
  assign slot_block          = '0;
  assign rtu_idu_issue_stall = 1'b0;
`endif

endmodule

// File: tb/tb_aq_rtu_wb_arb.sv
// Directed testbench for aq_rtu_wb_arb (default STARVE_LIMIT = 8).
// Inputs change 1 time unit after the rising edge. Outputs are sampled on
// the falling edge. Stall expectations depend on AQ_RTU_WB_ARB_STARVE_EN.
module tb_aq_rtu_wb_arb;

  logic        forever_cpuclk;
  logic        cpurst;
  logic        rbus_wb_vld;
  logic [5:0]  rbus_wb_preg;
  logic [63:0] rbus_wb_data;
  logic        vpu_wb_req;
  logic [5:0]  vpu_wb_preg;
  logic [63:0] vpu_wb_data;
  logic        vpu_wb_grnt;
  logic        div_wb_req;
  logic [5:0]  div_wb_preg;
  logic [63:0] div_wb_data;
  logic        div_wb_grnt;
  logic        wb0_vld;
  logic [5:0]  wb0_preg;
  logic [63:0] wb0_data;
  logic        rtu_idu_issue_stall;
  logic        wb_arb_idle;

  int checks;
  int errors;
  int stall_seen;

`ifdef AQ_RTU_WB_ARB_STARVE_EN
  localparam logic STALL_EXP = 1'b1;
  localparam logic BLOCK_EXP = 1'b1;
`else
  localparam logic STALL_EXP = 1'b0;
  localparam logic BLOCK_EXP = 1'b0;
`endif

  aq_rtu_wb_arb #(.STARVE_LIMIT(8)) dut (
    .forever_cpuclk      (forever_cpuclk),
    .cpurst              (cpurst),
    .rbus_wb_vld         (rbus_wb_vld),
    .rbus_wb_preg        (rbus_wb_preg),
    .rbus_wb_data        (rbus_wb_data),
    .vpu_wb_req          (vpu_wb_req),
    .vpu_wb_preg         (vpu_wb_preg),
    .vpu_wb_data         (vpu_wb_data),
    .vpu_wb_grnt         (vpu_wb_grnt),
    .div_wb_req          (div_wb_req),
    .div_wb_preg         (div_wb_preg),
    .div_wb_data         (div_wb_data),
    .div_wb_grnt         (div_wb_grnt),
    .wb0_vld             (wb0_vld),
    .wb0_preg            (wb0_preg),
    .wb0_data            (wb0_data),
    .rtu_idu_issue_stall (rtu_idu_issue_stall),
    .wb_arb_idle         (wb_arb_idle)
  );

  initial forever_cpuclk = 1'b0;
  always #5 forever_cpuclk = ~forever_cpuclk;

  // Sticky record of any stall seen during the run.
  always @(negedge forever_cpuclk) begin
    if (rtu_idu_issue_stall === 1'b1) stall_seen = 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic mid();
    @(negedge forever_cpuclk);
  endtask

  initial begin
    checks = 0; errors = 0; stall_seen = 0;
    cpurst = 1'b1;
    rbus_wb_vld = 0; rbus_wb_preg = '0; rbus_wb_data = '0;
    vpu_wb_req = 0; vpu_wb_preg = '0; vpu_wb_data = '0;
    div_wb_req = 0; div_wb_preg = '0; div_wb_data = '0;

    // Reset state
    repeat (3) @(posedge forever_cpuclk);
    mid();
    chk("rst_wb0_vld", 64'(wb0_vld), 64'd0);
    chk("rst_vpu_grnt", 64'(vpu_wb_grnt), 64'd1);
    chk("rst_div_grnt", 64'(div_wb_grnt), 64'd1);
    chk("rst_stall", 64'(rtu_idu_issue_stall), 64'd0);
    chk("rst_idle", 64'(wb_arb_idle), 64'd1);
    next_cycle(); cpurst = 1'b0;
    mid();
    chk("post_rst_idle", 64'(wb_arb_idle), 64'd1);
    $display("txn reset done");

    // Single VPU writeback with one-cycle latency
    next_cycle(); vpu_wb_req = 1; vpu_wb_preg = 6'd5; vpu_wb_data = 64'hA5;
    mid();
    chk("single_grnt_n", 64'(vpu_wb_grnt), 64'd1);
    chk("single_wb0_n", 64'(wb0_vld), 64'd0);
    next_cycle(); vpu_wb_req = 0;
    mid();
    chk("single_wb0_vld", 64'(wb0_vld), 64'd1);
    chk("single_wb0_preg", 64'(wb0_preg), 64'd5);
    chk("single_wb0_data", wb0_data, 64'hA5);
    chk("single_grnt_n1", 64'(vpu_wb_grnt), 64'd1);
    next_cycle();
    mid();
    chk("single_idle", 64'(wb_arb_idle), 64'd1);
    $display("txn vpu_single done");

    // Contested requests, pointer 0: VPU is written first
    next_cycle();
    vpu_wb_req = 1; vpu_wb_preg = 6'd1; vpu_wb_data = 64'h11;
    div_wb_req = 1; div_wb_preg = 6'd2; div_wb_data = 64'h22;
    mid();
    chk("rr0_div_grnt_n", 64'(div_wb_grnt), 64'd1);
    next_cycle(); vpu_wb_req = 0; div_wb_req = 0;
    mid();
    chk("rr0_first_preg", 64'(wb0_preg), 64'd1);
    chk("rr0_first_data", wb0_data, 64'h11);
    chk("rr0_div_grnt_wait", 64'(div_wb_grnt), 64'd0);
    next_cycle();
    mid();
    chk("rr0_second_vld", 64'(wb0_vld), 64'd1);
    chk("rr0_second_preg", 64'(wb0_preg), 64'd2);
    chk("rr0_second_data", wb0_data, 64'h22);
    next_cycle();
    mid();
    chk("rr0_idle", 64'(wb_arb_idle), 64'd1);
    $display("txn contested_ptr0 done");

    // Contested requests, pointer now 1: DIV is written first
    next_cycle();
    vpu_wb_req = 1; vpu_wb_preg = 6'd3; vpu_wb_data = 64'h33;
    div_wb_req = 1; div_wb_preg = 6'd4; div_wb_data = 64'h44;
    next_cycle(); vpu_wb_req = 0; div_wb_req = 0;
    mid();
    chk("rr1_first_preg", 64'(wb0_preg), 64'd4);
    chk("rr1_first_data", wb0_data, 64'h44);
    next_cycle();
    mid();
    chk("rr1_second_preg", 64'(wb0_preg), 64'd3);
    chk("rr1_second_data", wb0_data, 64'h33);
    $display("txn contested_ptr1 done");

    // Drain and refill in the same cycle
    next_cycle(); vpu_wb_req = 1; vpu_wb_preg = 6'd7; vpu_wb_data = 64'h77;
    next_cycle(); vpu_wb_preg = 6'd8; vpu_wb_data = 64'h88;
    mid();
    chk("refill_grnt", 64'(vpu_wb_grnt), 64'd1);
    chk("refill_old_preg", 64'(wb0_preg), 64'd7);
    chk("refill_old_data", wb0_data, 64'h77);
    next_cycle(); vpu_wb_req = 0;
    mid();
    chk("refill_new_vld", 64'(wb0_vld), 64'd1);
    chk("refill_new_preg", 64'(wb0_preg), 64'd8);
    chk("refill_new_data", wb0_data, 64'h88);
    next_cycle();
    mid();
    chk("refill_idle", 64'(wb_arb_idle), 64'd1);
    $display("txn drain_refill done");

    // rbus takes priority over a pending slot
    next_cycle(); vpu_wb_req = 1; vpu_wb_preg = 6'd9; vpu_wb_data = 64'h99;
    next_cycle(); vpu_wb_req = 0;
    rbus_wb_vld = 1; rbus_wb_preg = 6'd10; rbus_wb_data = 64'hBEEF;
    mid();
    chk("prio_rbus_preg", 64'(wb0_preg), 64'd10);
    chk("prio_rbus_data", wb0_data, 64'hBEEF);
    chk("prio_vpu_grnt", 64'(vpu_wb_grnt), 64'd0);
    chk("prio_idle", 64'(wb_arb_idle), 64'd0);
    next_cycle(); rbus_wb_vld = 0;
    mid();
    chk("prio_slot_preg", 64'(wb0_preg), 64'd9);
    chk("prio_slot_data", wb0_data, 64'h99);
    next_cycle();
    $display("txn rbus_priority done");

    // Starvation: rbus held high while the VPU slot is pending
    next_cycle();
    rbus_wb_vld = 1; rbus_wb_preg = 6'd12; rbus_wb_data = 64'hC0DE;
    vpu_wb_req = 1; vpu_wb_preg = 6'd13; vpu_wb_data = 64'hD00D;
    mid();
    chk("starve_grnt", 64'(vpu_wb_grnt), 64'd1);
    next_cycle(); vpu_wb_req = 0;
    repeat (8) next_cycle();
    mid();
    chk("starve_pre_stall", 64'(rtu_idu_issue_stall), 64'd0);
    chk("starve_rbus_data", wb0_data, 64'hC0DE);
    next_cycle();
    mid();
    chk("starve_stall", 64'(rtu_idu_issue_stall), 64'(STALL_EXP));
    next_cycle(); rbus_wb_vld = 0;
    mid();
    chk("starve_vpu_preg", 64'(wb0_preg), 64'd13);
    chk("starve_vpu_data", wb0_data, 64'hD00D);
    chk("starve_stall_hold", 64'(rtu_idu_issue_stall), 64'(STALL_EXP));
    next_cycle();
    mid();
    chk("drain_stall", 64'(rtu_idu_issue_stall), 64'(STALL_EXP));
    chk("drain_vpu_block", 64'(vpu_wb_grnt), 64'(!BLOCK_EXP));
    chk("drain_div_grnt", 64'(div_wb_grnt), 64'd1);
    next_cycle();
    mid();
    chk("normal_stall", 64'(rtu_idu_issue_stall), 64'd0);
    chk("normal_idle", 64'(wb_arb_idle), 64'd1);
    $display("txn starvation done");

    // Reset while both slots are pending discards them
    next_cycle();
    vpu_wb_req = 1; vpu_wb_preg = 6'd20; vpu_wb_data = 64'h2020;
    div_wb_req = 1; div_wb_preg = 6'd21; div_wb_data = 64'h2121;
    next_cycle(); vpu_wb_req = 0; div_wb_req = 0; cpurst = 1'b1;
    mid();
    chk("mrst_wb0_vld", 64'(wb0_vld), 64'd0);
    chk("mrst_idle", 64'(wb_arb_idle), 64'd1);
    chk("mrst_grnt", 64'({vpu_wb_grnt, div_wb_grnt}), 64'd3);
    next_cycle(); cpurst = 1'b0;
    mid();
    chk("mrst_after_vld", 64'(wb0_vld), 64'd0);
    chk("mrst_after_idle", 64'(wb_arb_idle), 64'd1);
    next_cycle();
    mid();
    chk("mrst_no_wb", 64'(wb0_vld), 64'd0);
    $display("txn mid_reset done");

`ifndef AQ_RTU_WB_ARB_STARVE_EN
    chk("stall_never", 64'(stall_seen), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aq_rtu_wb_arb.md
AQ_RTU_WB_ARB -- requirements
Module: aq_rtu_wb_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning cycles a pending slot may wait under continuous rbus writeback before a stall request (range 2..15).
REQ-002 SHALL have port forever_cpuclk  in  1  the single clock; all state is on its rising edge.
REQ-003 SHALL have port cpurst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports rbus_wb_vld/rbus_wb_preg/rbus_wb_data  in  1/6/64  registered rbus writeback; highest priority, never stalled.
REQ-005 SHALL have ports vpu_wb_req/vpu_wb_preg/vpu_wb_data  in  1/6/64  VPU GPR writeback request.
REQ-006 SHALL have port vpu_wb_grnt  out  1  VPU request accepted this cycle.
REQ-007 SHALL have ports div_wb_req/div_wb_preg/div_wb_data  in  1/6/64  divider writeback request.
REQ-008 SHALL have port div_wb_grnt  out  1  divider request accepted this cycle.
REQ-009 SHALL have ports wb0_vld/wb0_preg/wb0_data  out  1/6/64  shared writeback port 0 to IDU.
REQ-010 SHALL have port rtu_idu_issue_stall  out  1  request IDU to stop issuing rbus producers.
REQ-011 SHALL have port wb_arb_idle  out  1  no slot pending and wb0_vld low.

Function
REQ-012 SHALL hold one holding slot per requester (vld, preg, data); a request is captured when req && grnt.
REQ-013 SHALL drive a requester's grnt = slot empty OR slot drained to wb0 this cycle (same-cycle drain and refill allowed).
REQ-014 SHALL drive wb0 from rbus when rbus_wb_vld, else from a pending slot, else wb0_vld = 0; wb0 is combinational from rbus inputs and slot registers.
REQ-015 SHALL, when both slots pending and rbus idle, pick by a 1-bit round-robin pointer (0 = VPU first); pointer flips to the other requester only when a contested pick is made.
REQ-016 SHALL give minimum latency of one cycle: request accepted in cycle N is earliest on wb0 in cycle N+1.
REQ-017 SHALL clear a slot's vld in the cycle after it drives wb0; data/preg registers load only on capture.
REQ-018 SHALL keep a 4-bit starve counter: increments (saturating at STARVE_LIMIT) each cycle any slot is pending and rbus_wb_vld is high; clears whenever a slot drains.
REQ-019 SHALL implement starvation FSM NORMAL -> STALL (counter == STARVE_LIMIT) -> DRAIN (first cycle rbus_wb_vld low) -> NORMAL (both slots empty).
REQ-020 SHALL assert rtu_idu_issue_stall in STALL and DRAIN, low in NORMAL.
REQ-021 SHALL keep grnt low for new requests while in DRAIN if that requester's slot was already drained, guaranteeing DRAIN terminates.
REQ-022 SHALL assert wb_arb_idle = !vpu slot vld && !div slot vld && !wb0_vld.

Reset
REQ-023 SHALL on cpurst clear both slot vld, RR pointer = 0, counter = 0, FSM = NORMAL; outputs wb0_vld = 0, grnts = 1, issue_stall = 0, idle = 1; data/preg registers are not reset.
REQ-024 SHALL, on reset mid-operation, discard pending slots without writeback.

Configuration
REQ-025 SHALL compile starvation counter and FSM only when AQ_RTU_WB_ARB_STARVE_EN is defined; without it rtu_idu_issue_stall is tied 0, REQ-021 is inactive, and arbitration is otherwise identical.

Structure
REQ-026 SHALL place FSM state encoding (NORMAL=2'b00, STALL=2'b01, DRAIN=2'b10) and the 6-bit preg / 64-bit data width constants in the shared RTU package.
REQ-027 SHALL use one sub-module aq_rtu_wb_slot (single-entry valid/preg/data holding register with capture/drain), instantiated twice.

Verification
REQ-028 SHALL cover: vpu_wb_req with preg 5, data 0xA5 in cycle N, rbus idle -> wb0_vld, preg 5, data 0xA5 in N+1; vpu_wb_grnt stays 1.
REQ-029 SHALL cover: VPU and DIV request same cycle, rbus idle, pointer 0 -> VPU on wb0 in N+1, DIV in N+2, pointer = 1 after.
REQ-030 SHALL cover: rbus_wb_vld held high, VPU slot pending, STARVE_LIMIT 8 -> issue_stall rises after 8 cycles; rbus drops -> VPU written, FSM back to NORMAL, stall low.
REQ-031 SHALL cover: slot draining and new vpu_wb_req same cycle -> grnt 1, new entry on wb0 next cycle, no loss.
REQ-032 SHALL cover: cpurst asserted with both slots pending -> next cycle wb0_vld 0, idle 1, no writeback of discarded entries; macro undefined -> issue_stall never asserts.
